// File: rtl/ddr_wr_burst_gen.sv
// Write burst generator for one arbiter port: drains an FWFT pixel FIFO into a
// rotating set of linear frame buffers as bursts of up to BURST_LEN beats.
module ddr_wr_burst_gen #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter logic [31:0] FRAME_WORDS  = 32'd64800,
    parameter logic [31:0] FRAME_STRIDE = 32'h0020_0000,
    parameter int          NUM_FRAMES   = 3,
    parameter logic [9:0]  BURST_LEN    = 10'd64,
    parameter logic [31:0] ADDR_INC     = 32'd8,
    parameter int          CNT_W        = 11
) (
    input  logic             ui_clk,
    input  logic             ui_rst,
    input  logic             frame_start,
    input  logic [CNT_W-1:0] fifo_rd_count,
    output logic             fifo_rd_en,
    input  logic [255:0]     fifo_rd_data,
    output logic             wr_burst_req,
    output logic [31:0]      wr_burst_addr,
    output logic [9:0]       wr_burst_len,
    input  logic             wr_ready,
    input  logic             wr_fifo_re,
    output logic [255:0]     wr_fifo_data,
    input  logic             wr_burst_finish,
    output logic [2:0]       wr_frame_idx,
    output logic             frame_done,
    output logic             err_underrun,
    output logic             err_len
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DATA = 2'd1,
        REQ       = 2'd2,
        DONE      = 2'd3
    } state_t;

    localparam logic [2:0] LAST_IDX = 3'(NUM_FRAMES - 1);

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic        first_q, first_d;
    logic        pending_q, pending_d;
    logic [31:0] offset_q, offset_d;
    logic [31:0] beats_left_q, beats_left_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic [9:0]  len_q, len_d;
    logic [9:0]  beat_cnt_q, beat_cnt_d;
    logic        frame_done_q, frame_done_d;
    logic [2:0]  wr_frame_idx_q, wr_frame_idx_d;
    logic        err_underrun_q, err_underrun_d;
    logic        err_len_q, err_len_d;

    logic [9:0]  len_next;
    logic [9:0]  beat_cnt_inc;
    logic [31:0] frame_base;
    logic [31:0] count_ext;
    logic [31:0] beats_after;
    logic        unused_wr_ready;

    assign unused_wr_ready = wr_ready;

    always_comb begin
        len_next     = (beats_left_q < {22'd0, BURST_LEN}) ? beats_left_q[9:0] : BURST_LEN;
        frame_base   = {29'd0, idx_q} * FRAME_STRIDE;
        count_ext    = 32'(fifo_rd_count);
        beats_after  = beats_left_q - {22'd0, len_q};
        // Saturate so a runaway pop stream cannot wrap back to a matching count.
        beat_cnt_inc = (wr_fifo_re && (beat_cnt_q != 10'h3FF)) ? beat_cnt_q + 10'd1 : beat_cnt_q;
    end

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        first_d        = first_q;
        pending_d      = pending_q;
        offset_d       = offset_q;
        beats_left_d   = beats_left_q;
        req_d          = req_q;
        addr_d         = addr_q;
        len_d          = len_q;
        beat_cnt_d     = beat_cnt_inc;
        frame_done_d   = 1'b0;
        wr_frame_idx_d = wr_frame_idx_q;
        err_underrun_d = err_underrun_q;
        err_len_d      = err_len_q;

        if (wr_fifo_re && (fifo_rd_count == '0)) begin
            err_underrun_d = 1'b1;
        end
        if (wr_fifo_re && (state_q != REQ)) begin
            err_len_d = 1'b1;
        end
        // A start request arriving mid-frame (including during DONE) waits its turn.
        if (frame_start && (state_q != IDLE)) begin
            pending_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (frame_start || pending_q) begin
                    state_d      = WAIT_DATA;
                    pending_d    = 1'b0;
                    beats_left_d = FRAME_WORDS;
                    offset_d     = 32'd0;
                    first_d      = 1'b0;
                    if (first_q) begin
                        idx_d = 3'd0;
                    end else begin
                        idx_d = (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;
                    end
                end
            end
            WAIT_DATA: begin
                if (count_ext >= {22'd0, len_next}) begin
                    state_d    = REQ;
                    req_d      = 1'b1;
                    addr_d     = BASE_ADDR + frame_base + offset_q;
                    len_d      = len_next;
                    beat_cnt_d = 10'd0;
                end
            end
            REQ: begin
                if (wr_burst_finish) begin
                    req_d        = 1'b0;
                    offset_d     = offset_q + ({22'd0, len_q} * ADDR_INC);
                    beats_left_d = beats_after;
                    if (beat_cnt_inc != len_q) begin
                        err_len_d = 1'b1;
                    end
                    if (beats_after != 32'd0) begin
                        state_d = WAIT_DATA;
                    end else begin
                        state_d        = DONE;
                        frame_done_d   = 1'b1;
                        wr_frame_idx_d = idx_q;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge ui_clk or posedge ui_rst) begin
        if (ui_rst) begin
            state_q        <= IDLE;
            idx_q          <= 3'd0;
            first_q        <= 1'b1;
            pending_q      <= 1'b0;
            offset_q       <= 32'd0;
            beats_left_q   <= 32'd0;
            req_q          <= 1'b0;
            addr_q         <= 32'd0;
            len_q          <= 10'd0;
            beat_cnt_q     <= 10'd0;
            frame_done_q   <= 1'b0;
            wr_frame_idx_q <= LAST_IDX;
            err_underrun_q <= 1'b0;
            err_len_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            first_q        <= first_d;
            pending_q      <= pending_d;
            offset_q       <= offset_d;
            beats_left_q   <= beats_left_d;
            req_q          <= req_d;
            addr_q         <= addr_d;
            len_q          <= len_d;
            beat_cnt_q     <= beat_cnt_d;
            frame_done_q   <= frame_done_d;
            wr_frame_idx_q <= wr_frame_idx_d;
            err_underrun_q <= err_underrun_d;
            err_len_q      <= err_len_d;
        end
    end

    // Beat path is a straight wire: the arbiter pops the FIFO head directly.
    assign fifo_rd_en    = wr_fifo_re;
    assign wr_fifo_data  = fifo_rd_data;
    assign wr_burst_req  = req_q;
    assign wr_burst_addr = addr_q;
    assign wr_burst_len  = len_q;
    assign wr_frame_idx  = wr_frame_idx_q;
    assign frame_done    = frame_done_q;
    assign err_underrun  = err_underrun_q;
    assign err_len       = err_len_q;

endmodule

// File: tb/tb_ddr_wr_burst_gen.sv
// Scoreboard bench for ddr_wr_burst_gen: random FIFO fill and arbiter pacing,
// expected bursts and frame indices computed from frame/burst arithmetic.
module tb_ddr_wr_burst_gen;

    localparam int          NF     = 3;
    localparam logic [31:0] FW     = 32'd100;
    localparam logic [9:0]  BL     = 10'd64;
    localparam logic [31:0] STRIDE = 32'h0020_0000;
    localparam logic [31:0] INC    = 32'd8;
    localparam logic [31:0] BASE   = 32'h0000_0000;

    logic         ui_clk;
    logic         ui_rst;
    logic         frame_start;
    logic [10:0]  fifo_rd_count;
    logic         fifo_rd_en;
    logic [255:0] fifo_rd_data;
    logic         wr_burst_req;
    logic [31:0]  wr_burst_addr;
    logic [9:0]   wr_burst_len;
    logic         wr_ready;
    logic         wr_fifo_re;
    logic [255:0] wr_fifo_data;
    logic         wr_burst_finish;
    logic [2:0]   wr_frame_idx;
    logic         frame_done;
    logic         err_underrun;
    logic         err_len;

    ddr_wr_burst_gen #(
        .BASE_ADDR(BASE), .FRAME_WORDS(FW), .FRAME_STRIDE(STRIDE), .NUM_FRAMES(NF),
        .BURST_LEN(BL), .ADDR_INC(INC), .CNT_W(11)
    ) dut (
        .ui_clk(ui_clk), .ui_rst(ui_rst), .frame_start(frame_start),
        .fifo_rd_count(fifo_rd_count), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
        .wr_burst_req(wr_burst_req), .wr_burst_addr(wr_burst_addr), .wr_burst_len(wr_burst_len),
        .wr_ready(wr_ready), .wr_fifo_re(wr_fifo_re), .wr_fifo_data(wr_fifo_data),
        .wr_burst_finish(wr_burst_finish), .wr_frame_idx(wr_frame_idx), .frame_done(frame_done),
        .err_underrun(err_underrun), .err_len(err_len)
    );

    typedef struct {
        logic [31:0] addr;
        logic [9:0]  len;
    } burst_t;

    burst_t exp_q[$];
    int     fd_q[$];
    int     checks = 0;
    int     failures = 0;
    int     frame_no = 0;
    int     rises = 0;
    int     fill_mode = 0;   // 0 grow randomly, 1 hold, 2 empty, 3 full
    logic   short_mode = 1'b0;
    logic   manual_re = 1'b0;
    logic   chk_gap = 1'b0;

    initial ui_clk = 1'b0;
    always #5 ui_clk = ~ui_clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s timed out", name);
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference: a frame is FW beats cut into BL-sized chunks from its buffer base.
    task automatic model_frame();
        int          idx;
        int          rem;
        int          l;
        logic [31:0] off;
        burst_t      b;
        idx = frame_no % NF;
        frame_no++;
        rem = int'(FW);
        off = 32'd0;
        while (rem > 0) begin
            l = (rem < int'(BL)) ? rem : int'(BL);
            b.addr = BASE + 32'(idx) * STRIDE + off;
            b.len  = 10'(l);
            exp_q.push_back(b);
            off = off + 32'(l) * INC;
            rem = rem - l;
        end
        fd_q.push_back(idx);
    endtask

    task automatic pulse_start();
        @(negedge ui_clk);
        frame_start = 1'b1;
        @(negedge ui_clk);
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while ((fd_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
            @(negedge ui_clk);
            n++;
        end
        if (n >= budget) begin
            fail_timeout(name);
            exp_q.delete();
            fd_q.delete();
        end
        repeat (2) @(negedge ui_clk);
    endtask

    task automatic wait_rise(input int budget, input string name);
        int r0 = rises;
        int n = 0;
        while (rises == r0 && n < budget) begin
            @(negedge ui_clk);
            n++;
        end
        if (n >= budget) fail_timeout(name);
    endtask

    task automatic manual_pop();
        @(posedge ui_clk);
        #2 manual_re = 1'b1;
        @(posedge ui_clk);
        #2 manual_re = 1'b0;
        repeat (2) @(negedge ui_clk);
    endtask

    // FIFO model: pops take effect at the clock edge, fill level follows fill_mode.
    initial begin
        fifo_rd_count = 11'd0;
        fifo_rd_data  = rand256();
        forever begin
            @(posedge ui_clk);
            #1;
            if (wr_fifo_re) begin
                fifo_rd_data = rand256();
                if (fifo_rd_count != 11'd0) fifo_rd_count = fifo_rd_count - 11'd1;
            end
            case (fill_mode)
                0: if (fifo_rd_count < 11'd1500) fifo_rd_count = fifo_rd_count + 11'($urandom_range(0, 3));
                2: fifo_rd_count = 11'd0;
                3: fifo_rd_count = 11'd300;
                default: ;
            endcase
        end
    end

    // Arbiter model: pops the granted number of beats with random gaps, then finishes.
    initial begin
        int  done_beats;
        int  target;
        logic busy;
        busy = 1'b0;
        done_beats = 0;
        target = 0;
        wr_fifo_re = 1'b0;
        wr_burst_finish = 1'b0;
        forever begin
            @(negedge ui_clk);
            if (ui_rst) begin
                busy = 1'b0;
                wr_fifo_re = 1'b0;
                wr_burst_finish = 1'b0;
            end else begin
                wr_fifo_re = 1'b0;
                if (wr_burst_finish) begin
                    wr_burst_finish = 1'b0;
                    busy = 1'b0;
                end else begin
                    if (!busy && wr_burst_req) begin
                        busy = 1'b1;
                        done_beats = 0;
                        target = short_mode ? int'(wr_burst_len) - 1 : int'(wr_burst_len);
                    end
                    if (busy) begin
                        if (done_beats < target) begin
                            if ($urandom_range(0, 3) != 0) begin
                                wr_fifo_re = 1'b1;
                                done_beats++;
                            end
                        end else begin
                            wr_burst_finish = 1'b1;
                        end
                    end
                end
                if (manual_re) wr_fifo_re = 1'b1;
                #1;
                chk("fifo_rd_en", fifo_rd_en, wr_fifo_re);
                if (wr_fifo_re) chk("beat_data", wr_fifo_data, fifo_rd_data);
            end
        end
    end

    // Monitor: pops the scoreboard whenever a burst request or frame_done appears.
    initial begin
        burst_t      cur;
        logic        req_prev = 1'b0;
        logic        fd_prev = 1'b0;
        logic        after_done = 1'b0;
        logic        gap_done = 1'b0;
        logic [10:0] cnt_prev = 11'd0;
        int          cyc = 0;
        int          last_done = 0;
        int          fidx;
        cur.addr = 32'd0;
        cur.len  = 10'd0;
        forever begin
            @(negedge ui_clk);
            cyc++;
            if (ui_rst) begin
                req_prev = 1'b0;
                fd_prev = 1'b0;
            end else begin
                if (wr_burst_req && !req_prev) begin
                    rises++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_burst addr=%0h len=%0d", wr_burst_addr, wr_burst_len);
                    end else begin
                        cur = exp_q.pop_front();
                        chk("burst_addr", wr_burst_addr, cur.addr);
                        chk("burst_len", wr_burst_len, cur.len);
                        chk("count_guard", (cnt_prev >= 11'(cur.len)), 1'b1);
                        if (chk_gap && after_done && !gap_done) begin
                            gap_done = 1'b1;
                            chk("pending_start_gap", cyc - last_done, 3);
                        end
                    end
                    after_done = 1'b0;
                end else if (wr_burst_req) begin
                    chk("addr_stable", wr_burst_addr, cur.addr);
                    chk("len_stable", wr_burst_len, cur.len);
                end
                if (frame_done) begin
                    chk("frame_done_width", fd_prev, 1'b0);
                    if (fd_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_frame_done idx=%0d", wr_frame_idx);
                    end else begin
                        fidx = fd_q.pop_front();
                        chk("wr_frame_idx", wr_frame_idx, 3'(fidx));
                    end
                    after_done = 1'b1;
                    last_done = cyc;
                end
                req_prev = wr_burst_req;
                fd_prev = frame_done;
            end
            cnt_prev = fifo_rd_count;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        ui_rst = 1'b1;
        frame_start = 1'b0;
        wr_ready = 1'b1;
        repeat (2) @(negedge ui_clk);
        chk("rst_req", wr_burst_req, 1'b0);
        chk("rst_addr", wr_burst_addr, 32'd0);
        chk("rst_len", wr_burst_len, 10'd0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_err_underrun", err_underrun, 1'b0);
        chk("rst_err_len", err_len, 1'b0);
        chk("rst_wr_frame_idx", wr_frame_idx, 3'(NF - 1));
        ui_rst = 1'b0;

        // Data available but no frame_start: nothing may be requested.
        fill_mode = 3;
        repeat (20) @(negedge ui_clk);
        chk("idle_no_req", wr_burst_req, 1'b0);

        // Four frames with a slowly filling FIFO: buffer rotation 0,1,2,0.
        for (int f = 0; f < 4; f++) begin
            fill_mode = 2;
            repeat (2) @(negedge ui_clk);
            fill_mode = 0;
            model_frame();
            pulse_start();
            wait_done(3000, "frame_rotation");
        end
        chk("idx_after_four", wr_frame_idx, 3'd0);

        // Mid-burst start is deferred until after DONE; a second one is dropped.
        fill_mode = 3;
        model_frame();
        pulse_start();
        wait_rise(200, "pending_first_req");
        model_frame();
        chk_gap = 1'b1;
        pulse_start();
        repeat (3) @(negedge ui_clk);
        pulse_start();
        wait_done(3000, "pending_frames");
        repeat (30) @(negedge ui_clk);
        chk("no_extra_frame", wr_burst_req, 1'b0);

        // Short burst: 63 beats against len 64 sets a sticky err_len.
        chk("err_len_clear", err_len, 1'b0);
        short_mode = 1'b1;
        model_frame();
        pulse_start();
        wait_rise(200, "short_req");
        @(negedge ui_clk);
        short_mode = 1'b0;
        wait_done(3000, "short_frame");
        chk("err_len_set", err_len, 1'b1);
        model_frame();
        pulse_start();
        wait_done(3000, "after_short_frame");
        chk("err_len_sticky", err_len, 1'b1);
        chk("no_underrun_yet", err_underrun, 1'b0);

        // Reset in the middle of a burst.
        model_frame();
        pulse_start();
        wait_rise(200, "reset_req");
        repeat (3) @(negedge ui_clk);
        @(posedge ui_clk);
        #3 ui_rst = 1'b1;
        #1 chk("async_req_drop", wr_burst_req, 1'b0);
        exp_q.delete();
        fd_q.delete();
        frame_no = 0;
        repeat (3) @(negedge ui_clk);
        chk("rst2_err_len", err_len, 1'b0);
        chk("rst2_wr_frame_idx", wr_frame_idx, 3'(NF - 1));
        ui_rst = 1'b0;
        repeat (20) @(negedge ui_clk);
        chk("post_rst_no_req", wr_burst_req, 1'b0);
        model_frame();
        pulse_start();
        wait_done(3000, "post_reset_frame");
        chk("post_rst_idx", wr_frame_idx, 3'd0);

        // Stray pops outside a burst, then with an empty FIFO.
        chk("err_len_clean", err_len, 1'b0);
        manual_pop();
        chk("stray_pop_err_len", err_len, 1'b1);
        chk("stray_pop_no_underrun", err_underrun, 1'b0);
        fill_mode = 2;
        repeat (2) @(negedge ui_clk);
        manual_pop();
        chk("underrun_set", err_underrun, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
